// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Owns the single mainMem port and shares it between three requesters: the
// program loader (preload writes), instruction fetch and the data stage.
// After reset only the loader may write. Once the loader pulses load_done the
// block switches to a pipelined scheduler. That scheduler issues at most one
// access per cycle, returns read data to the right owner RD_LAT cycles later,
// and raises stall to fetch whenever fetch loses the port.
//
// Ports
//   clock, reset_n        rising-edge clock, synchronous active-low reset
//   load_req/addr/data    loader write request (LOAD state only)
//   load_done             one-cycle pulse, loader finished -> RUN
//   load_gnt              loader write placed on the port this cycle
//   if_req/if_addr        fetch read request and PC
//   if_gnt                fetch read placed on the port this cycle
//   if_valid/data/pc      instruction return, tagged with its PC
//   if_pc_start           constant START_ADDRESS, first PC after load
//   stall                 fetch must hold its PC this cycle
//   flush                 squash every fetch return still in flight
//   d_req/wr/addr/wdata   data load/store request
//   d_gnt                 data access placed on the port this cycle
//   d_valid/d_rdata       load data return
//   d_err                 misaligned data request rejected this cycle
//   mem_*                 mainMem port (addr, data_in, data_out, acc_size,
//                         wren, enable, busy)
//   dbg_state             current scheduler state (0 = LOAD, 1 = RUN)
//
// Handshake: a requester holds its req together with its address and data
// until it sees its gnt in the same cycle. gnt=1 means the access was driven
// on mem_* that cycle, so the requester may move on at the next edge.
// Returns cannot be back-pressured. A read granted in cycle t produces exactly
// one valid pulse in cycle t+RD_LAT, unless a flush squashes that fetch.

module mem_port_arbiter #(
  parameter logic [31:0] START_ADDRESS = 32'h80020000,
  parameter int          RD_LAT        = 1,
  parameter int          STARVE_MAX    = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        load_req,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
  input  logic        load_done,
  output logic        load_gnt,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_valid,
  output logic [31:0] if_data,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_start,
  output logic        stall,
  input  logic        flush,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_valid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out,
  output logic [1:0]  mem_acc_size,
  output logic        mem_wren,
  output logic        mem_enable,
  input  logic        mem_busy,
  output logic        dbg_state
);

  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam int HEAD  = RD_LAT - 1;

  typedef enum logic {
    S_LOAD = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   starve_q, starve_d;

  // Last values driven on the address/data pins. These are replayed whenever
  // nothing issues, so the port holds steady while idle or busy.
  logic [31:0]        addr_q, wdata_q;

  // Read tag pipe: one slot per cycle of memory latency. Slot HEAD lines up
  // with mem_data_out. f = owner is fetch, pc = PC carried for fetch returns.
  logic               pipe_v  [RD_LAT];
  logic               pipe_f  [RD_LAT];
  logic [31:0]        pipe_pc [RD_LAT];

  logic               push_v, push_f;
  logic               d_misaligned, d_ok, starve_full, fetch_forced;

  // Word accesses only: the low two address bits must be zero.
  assign d_misaligned = (d_addr[1:0] != 2'b00);
  assign d_ok         = d_req && !d_misaligned;
  assign starve_full  = (starve_q >= CNT_W'(STARVE_MAX));
  assign fetch_forced = if_req && starve_full;

  assign if_pc_start  = START_ADDRESS;
  assign mem_acc_size = 2'b00;
  assign dbg_state    = state_q;

  // ---------------------------------------------------------------------
  // Next state, grants and port drive
  // ---------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    load_gnt    = 1'b0;
    if_gnt      = 1'b0;
    d_gnt       = 1'b0;
    d_err       = 1'b0;
    stall       = 1'b1;
    mem_enable  = 1'b0;
    mem_wren    = 1'b0;
    mem_addr    = addr_q;
    mem_data_in = wdata_q;
    push_v      = 1'b0;
    push_f      = 1'b0;

    // Nothing may reach the port while reset is asserted, even though the
    // registers only clear at the edge.
    if (reset_n) begin
      case (state_q)
        S_LOAD: begin
          if (load_req && !mem_busy) begin
            load_gnt    = 1'b1;
            mem_enable  = 1'b1;
            mem_wren    = 1'b1;
            mem_addr    = load_addr;
            mem_data_in = load_data;
          end
          // A write offered with load_done is still issued above.
          if (load_done) begin
            state_d = S_RUN;
          end
        end

        S_RUN: begin
          d_err = d_req && d_misaligned;

          if (!mem_busy) begin
            // Data beats fetch, except when fetch has been passed over
            // STARVE_MAX times in a row. A rejected (misaligned) data
            // request leaves the port free for fetch in the same cycle.
            if (d_ok && !fetch_forced) begin
              d_gnt      = 1'b1;
              mem_enable = 1'b1;
              mem_wren   = d_wr;
              mem_addr   = d_addr;
              if (d_wr) begin
                mem_data_in = d_wdata;
              end
              // Stores complete on issue; only loads expect a return.
              push_v = !d_wr;
              push_f = 1'b0;
            end else if (if_req) begin
              if_gnt     = 1'b1;
              mem_enable = 1'b1;
              mem_wren   = 1'b0;
              mem_addr   = if_addr;
              push_v     = 1'b1;
              push_f     = 1'b1;
            end
          end

          stall = if_req && !if_gnt;

          // Count data grants taken while fetch was waiting. The count does
          // not change on cycles where busy blocks everything.
          if (!if_req || if_gnt) begin
            starve_d = '0;
          end else if (d_gnt && !starve_full) begin
            starve_d = starve_q + CNT_W'(1);
          end
        end

        default: begin
          state_d = S_LOAD;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // State, hold registers and read tag pipe
  // ---------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= S_LOAD;
      starve_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_v[i]  <= 1'b0;
        pipe_f[i]  <= 1'b0;
        pipe_pc[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      addr_q   <= mem_addr;
      wdata_q  <= mem_data_in;

      // A fetch issued in the flush cycle belongs to the new stream, so the
      // slot being pushed is never squashed.
      pipe_v[0]  <= push_v;
      pipe_f[0]  <= push_f;
      pipe_pc[0] <= if_addr;

      // Older fetch tags die on flush; data tags are untouched.
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_v[i]  <= pipe_v[i-1] && !(flush && pipe_f[i-1]);
        pipe_f[i]  <= pipe_f[i-1];
        pipe_pc[i] <= pipe_pc[i-1];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Returns
  // ---------------------------------------------------------------------
  // The head slot is live in the same cycle mem_data_out carries its word.
  // A flush in that cycle also hides the head fetch return.
  assign if_valid = reset_n && pipe_v[HEAD] &&  pipe_f[HEAD] && !flush;
  assign d_valid  = reset_n && pipe_v[HEAD] && !pipe_f[HEAD];
  assign if_data  = if_valid ? mem_data_out  : '0;
  assign if_pc    = if_valid ? pipe_pc[HEAD] : '0;
  assign d_rdata  = d_valid  ? mem_data_out  : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam logic [31:0] START      = 32'h80020000;
  localparam int          RD_LAT     = 2;
  localparam int          STARVE_MAX = 4;

  // ---------------- clock / reset / signals ----------------
  logic        clock = 1'b0;
  logic        reset_n;
  logic        load_req, load_done, if_req, flush, d_req, d_wr, mem_busy;
  logic [31:0] load_addr, load_data, if_addr, d_addr, d_wdata, mem_data_out;
  logic        load_gnt, if_gnt, if_valid, stall, d_gnt, d_valid, d_err;
  logic        mem_wren, mem_enable, dbg_state;
  logic [31:0] if_data, if_pc, if_pc_start, d_rdata, mem_addr, mem_data_in;
  logic [1:0]  mem_acc_size;

  always #5 clock = ~clock;

  mem_port_arbiter #(
    .START_ADDRESS(START),
    .RD_LAT(RD_LAT),
    .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .load_req(load_req), .load_addr(load_addr), .load_data(load_data),
    .load_done(load_done), .load_gnt(load_gnt),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid),
    .if_data(if_data), .if_pc(if_pc), .if_pc_start(if_pc_start),
    .stall(stall), .flush(flush),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
    .mem_acc_size(mem_acc_size), .mem_wren(mem_wren), .mem_enable(mem_enable),
    .mem_busy(mem_busy), .dbg_state(dbg_state)
  );

  int checks;
  int errors;
  logic [31:0] words [3];

  // ---------------- mainMem stand-in ----------------
  logic [31:0] env_mem [logic [31:0]];
  logic [31:0] rd_line [RD_LAT];

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  always @(posedge clock) begin
    if (mem_enable && mem_wren) env_mem[mem_addr] = mem_data_in;
    if (mem_enable && !mem_wren)
      rd_line[0] <= env_mem.exists(mem_addr) ? env_mem[mem_addr] : dflt(mem_addr);
    else
      rd_line[0] <= 32'hDEAD_BEEF;
    for (int i = 1; i < RD_LAT; i++) rd_line[i] <= rd_line[i-1];
  end
  assign mem_data_out = rd_line[RD_LAT-1];

  // ---------------- reference model state ----------------
  typedef struct {
    int          due;
    bit          fetch;
    logic [31:0] pc;
    logic [31:0] data;
    bit          live;
  } ret_t;

  logic [31:0] ref_mem [logic [31:0]];

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    load_req = 0; load_addr = '0; load_data = '0; load_done = 0;
    if_req = 0; if_addr = '0; flush = 0;
    d_req = 0; d_wr = 0; d_addr = '0; d_wdata = '0; mem_busy = 0;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    idle_inputs();
    repeat (n) next_cycle();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    reset_n = 0;
    load_req = 1; load_addr = START; if_req = 1; if_addr = START;
    d_req = 1; d_addr = START + 32'd2;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checks++; if (load_gnt !== 1'b0) begin errors++; $display("FAIL reset load_gnt got %b exp 0", load_gnt); end
    checks++; if (if_gnt !== 1'b0) begin errors++; $display("FAIL reset if_gnt got %b exp 0", if_gnt); end
    checks++; if (d_gnt !== 1'b0) begin errors++; $display("FAIL reset d_gnt got %b exp 0", d_gnt); end
    checks++; if (d_err !== 1'b0) begin errors++; $display("FAIL reset d_err got %b exp 0", d_err); end
    checks++; if (if_valid !== 1'b0 || d_valid !== 1'b0) begin errors++; $display("FAIL reset valids got %b%b exp 00", if_valid, d_valid); end
    checks++; if (mem_enable !== 1'b0 || mem_wren !== 1'b0) begin errors++; $display("FAIL reset mem_en/wren got %b%b exp 00", mem_enable, mem_wren); end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL reset stall got %b exp 1", stall); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset mem_addr got %h exp 0", mem_addr); end
    checks++; if (if_data !== 32'h0 || d_rdata !== 32'h0) begin errors++; $display("FAIL reset data got %h %h exp 0", if_data, d_rdata); end
    checks++; if (if_pc_start !== START) begin errors++; $display("FAIL reset if_pc_start got %h exp %h", if_pc_start, START); end
    checks++; if (mem_acc_size !== 2'b00) begin errors++; $display("FAIL reset acc_size got %b exp 00", mem_acc_size); end
    checks++; if (dbg_state !== 1'b0) begin errors++; $display("FAIL reset state got %b exp 0", dbg_state); end
    @(posedge clock); #1;
    reset_n = 1;
    idle_inputs();
  endtask

  task automatic test_load();
    // A write offered while the memory is busy must wait.
    mem_busy = 1; load_req = 1; load_addr = START; load_data = words[0];
    @(negedge clock);
    checks++; if (load_gnt !== 1'b0 || mem_enable !== 1'b0) begin errors++; $display("FAIL load_busy gnt/en got %b%b exp 00", load_gnt, mem_enable); end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL load_busy stall got %b exp 1", stall); end
    next_cycle();
    for (int k = 0; k < 3; k++) begin
      idle_inputs();
      load_req = 1; load_addr = START + 32'(4 * k); load_data = words[k];
      load_done = (k == 2);
      if_req = 1; if_addr = START; d_req = 1; d_addr = START;
      @(negedge clock);
      checks++; if (load_gnt !== 1'b1) begin errors++; $display("FAIL load k=%0d load_gnt got %b exp 1", k, load_gnt); end
      checks++; if (mem_enable !== 1'b1 || mem_wren !== 1'b1) begin errors++; $display("FAIL load k=%0d en/wren got %b%b exp 11", k, mem_enable, mem_wren); end
      checks++; if (mem_addr !== load_addr) begin errors++; $display("FAIL load k=%0d mem_addr got %h exp %h", k, mem_addr, load_addr); end
      checks++; if (mem_data_in !== words[k]) begin errors++; $display("FAIL load k=%0d mem_data_in got %h exp %h", k, mem_data_in, words[k]); end
      checks++; if (stall !== 1'b1 || if_gnt !== 1'b0 || d_gnt !== 1'b0) begin errors++; $display("FAIL load k=%0d stall/if_gnt/d_gnt got %b%b%b exp 100", k, stall, if_gnt, d_gnt); end
      checks++; if (dbg_state !== 1'b0) begin errors++; $display("FAIL load k=%0d state got %b exp 0", k, dbg_state); end
      ref_mem[load_addr] = words[k];
      next_cycle();
    end
    idle_inputs();
    load_req = 1; load_addr = START + 32'h40;
    @(negedge clock);
    checks++; if (dbg_state !== 1'b1) begin errors++; $display("FAIL load_done state got %b exp 1", dbg_state); end
    checks++; if (load_gnt !== 1'b0 || mem_enable !== 1'b0) begin errors++; $display("FAIL run load_req gnt/en got %b%b exp 00", load_gnt, mem_enable); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL run idle stall got %b exp 0", stall); end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_fetch_b2b();
    for (int k = 0; k < 3 + RD_LAT + 1; k++) begin
      bit exp_g, exp_v;
      int idx;
      idle_inputs();
      if (k < 3) begin if_req = 1; if_addr = START + 32'(4 * k); end
      exp_g = (k < 3);
      idx = k - RD_LAT;
      exp_v = (idx >= 0) && (idx < 3);
      @(negedge clock);
      checks++; if (if_gnt !== exp_g) begin errors++; $display("FAIL b2b k=%0d if_gnt got %b exp %b", k, if_gnt, exp_g); end
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL b2b k=%0d stall got %b exp 0", k, stall); end
      if (exp_g) begin
        checks++; if (mem_addr !== if_addr || mem_wren !== 1'b0) begin errors++; $display("FAIL b2b k=%0d mem_addr/wren got %h %b exp %h 0", k, mem_addr, mem_wren, if_addr); end
      end
      checks++; if (if_valid !== exp_v) begin errors++; $display("FAIL b2b k=%0d if_valid got %b exp %b", k, if_valid, exp_v); end
      if (exp_v) begin
        checks++; if (if_data !== words[idx]) begin errors++; $display("FAIL b2b k=%0d if_data got %h exp %h", k, if_data, words[idx]); end
        checks++; if (if_pc !== START + 32'(4 * idx)) begin errors++; $display("FAIL b2b k=%0d if_pc got %h exp %h", k, if_pc, START + 32'(4 * idx)); end
      end
      checks++; if (d_valid !== 1'b0) begin errors++; $display("FAIL b2b k=%0d d_valid got %b exp 0", k, d_valid); end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_data_priority();
    for (int k = 0; k < RD_LAT + 3; k++) begin
      bit exp_dv, exp_iv;
      idle_inputs();
      if (k == 0) begin d_req = 1; d_wr = 0; d_addr = START + 32'd4; end
      if (k < 2) begin if_req = 1; if_addr = START + 32'd8; end
      exp_dv = (k == RD_LAT);
      exp_iv = (k == 1 + RD_LAT);
      @(negedge clock);
      if (k == 0) begin
        checks++; if (d_gnt !== 1'b1 || if_gnt !== 1'b0) begin errors++; $display("FAIL prio k0 d_gnt/if_gnt got %b%b exp 10", d_gnt, if_gnt); end
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL prio k0 stall got %b exp 1", stall); end
        checks++; if (mem_addr !== START + 32'd4 || mem_wren !== 1'b0) begin errors++; $display("FAIL prio k0 mem_addr/wren got %h %b", mem_addr, mem_wren); end
      end
      if (k == 1) begin
        checks++; if (if_gnt !== 1'b1 || stall !== 1'b0) begin errors++; $display("FAIL prio k1 if_gnt/stall got %b%b exp 10", if_gnt, stall); end
      end
      checks++; if (d_valid !== exp_dv) begin errors++; $display("FAIL prio k=%0d d_valid got %b exp %b", k, d_valid, exp_dv); end
      if (exp_dv) begin
        checks++; if (d_rdata !== words[1]) begin errors++; $display("FAIL prio d_rdata got %h exp %h", d_rdata, words[1]); end
      end
      checks++; if (if_valid !== exp_iv) begin errors++; $display("FAIL prio k=%0d if_valid got %b exp %b", k, if_valid, exp_iv); end
      if (exp_iv) begin
        checks++; if (if_data !== words[2] || if_pc !== START + 32'd8) begin errors++; $display("FAIL prio if_data/pc got %h %h exp %h %h", if_data, if_pc, words[2], START + 32'd8); end
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_starvation();
    for (int k = 0; k < 15; k++) begin
      bit exp_if;
      idle_inputs();
      d_req = 1; d_wr = 0; d_addr = START;
      if_req = 1; if_addr = START + 32'd4;
      exp_if = ((k % (STARVE_MAX + 1)) == STARVE_MAX);
      @(negedge clock);
      checks++; if (d_gnt !== !exp_if || if_gnt !== exp_if) begin errors++; $display("FAIL starve k=%0d d_gnt/if_gnt got %b%b exp %b%b", k, d_gnt, if_gnt, !exp_if, exp_if); end
      checks++; if (stall !== !exp_if) begin errors++; $display("FAIL starve k=%0d stall got %b exp %b", k, stall, !exp_if); end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_misaligned();
    for (int k = 0; k < RD_LAT + 3; k++) begin
      bit exp_iv;
      idle_inputs();
      if (k == 0) begin d_req = 1; d_wr = 0; d_addr = START + 32'd2; end
      if (k == 1) begin d_req = 1; d_wr = 1; d_addr = START + 32'd1; d_wdata = 32'hFFFF_FFFF; if_req = 1; if_addr = START; end
      exp_iv = (k == 1 + RD_LAT);
      @(negedge clock);
      if (k == 0) begin
        checks++; if (d_err !== 1'b1 || d_gnt !== 1'b0 || mem_enable !== 1'b0) begin errors++; $display("FAIL misalign k0 err/gnt/en got %b%b%b exp 100", d_err, d_gnt, mem_enable); end
      end
      if (k == 1) begin
        checks++; if (d_err !== 1'b1 || d_gnt !== 1'b0) begin errors++; $display("FAIL misalign k1 err/gnt got %b%b exp 10", d_err, d_gnt); end
        checks++; if (if_gnt !== 1'b1 || mem_addr !== START || mem_wren !== 1'b0) begin errors++; $display("FAIL misalign k1 if_gnt/addr/wren got %b %h %b", if_gnt, mem_addr, mem_wren); end
      end
      if (k >= 2) begin
        checks++; if (d_err !== 1'b0) begin errors++; $display("FAIL misalign k=%0d d_err got %b exp 0", k, d_err); end
      end
      checks++; if (d_valid !== 1'b0) begin errors++; $display("FAIL misalign k=%0d d_valid got %b exp 0", k, d_valid); end
      checks++; if (if_valid !== exp_iv) begin errors++; $display("FAIL misalign k=%0d if_valid got %b exp %b", k, if_valid, exp_iv); end
      if (exp_iv) begin
        checks++; if (if_data !== words[0]) begin errors++; $display("FAIL misalign if_data got %h exp %h", if_data, words[0]); end
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_flush();
    for (int k = 0; k < RD_LAT + 4; k++) begin
      bit exp_v;
      int idx;
      idle_inputs();
      if (k < 3) begin if_req = 1; if_addr = START + 32'(4 * k); end
      if (k == 2) flush = 1;
      idx = k - RD_LAT;
      // Fetches 0/1 die at the flush; fetch 2 is issued in the flush cycle.
      exp_v = (idx == 2) || (idx >= 0 && idx < 2 && k < 2);
      @(negedge clock);
      if (k < 3) begin
        checks++; if (if_gnt !== 1'b1) begin errors++; $display("FAIL flush k=%0d if_gnt got %b exp 1", k, if_gnt); end
      end
      checks++; if (if_valid !== exp_v) begin errors++; $display("FAIL flush k=%0d if_valid got %b exp %b", k, if_valid, exp_v); end
      if (exp_v && idx == 2) begin
        checks++; if (if_data !== words[2] || if_pc !== START + 32'd8) begin errors++; $display("FAIL flush survivor data/pc got %h %h exp %h %h", if_data, if_pc, words[2], START + 32'd8); end
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_busy();
    for (int k = 0; k < RD_LAT + 6; k++) begin
      bit exp_dv;
      idle_inputs();
      if (k < 4) begin d_req = 1; d_wr = 0; d_addr = START + 32'd8; end
      if (k < 5) begin if_req = 1; if_addr = START; end
      mem_busy = (k < 3);
      exp_dv = (k == 3 + RD_LAT);
      @(negedge clock);
      if (k < 3) begin
        checks++; if (d_gnt !== 1'b0 || if_gnt !== 1'b0 || mem_enable !== 1'b0) begin errors++; $display("FAIL busy k=%0d d_gnt/if_gnt/en got %b%b%b exp 000", k, d_gnt, if_gnt, mem_enable); end
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL busy k=%0d stall got %b exp 1", k, stall); end
      end
      if (k == 3) begin
        checks++; if (d_gnt !== 1'b1 || if_gnt !== 1'b0 || mem_addr !== START + 32'd8) begin errors++; $display("FAIL busy drop d_gnt/if_gnt/addr got %b%b %h", d_gnt, if_gnt, mem_addr); end
      end
      if (k == 4) begin
        checks++; if (if_gnt !== 1'b1 || stall !== 1'b0) begin errors++; $display("FAIL busy k4 if_gnt/stall got %b%b exp 10", if_gnt, stall); end
      end
      checks++; if (d_valid !== exp_dv) begin errors++; $display("FAIL busy k=%0d d_valid got %b exp %b", k, d_valid, exp_dv); end
      if (exp_dv) begin
        checks++; if (d_rdata !== words[2]) begin errors++; $display("FAIL busy d_rdata got %h exp %h", d_rdata, words[2]); end
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_reset_midflight();
    for (int k = 0; k < 8; k++) begin
      idle_inputs();
      if (k == 0) begin if_req = 1; if_addr = START; d_req = 0; end
      reset_n = (k != 1);
      load_done = (k == 6);
      @(negedge clock);
      if (k == 0) begin
        checks++; if (if_gnt !== 1'b1) begin errors++; $display("FAIL midreset k0 if_gnt got %b exp 1", if_gnt); end
      end
      checks++; if (if_valid !== 1'b0 || d_valid !== 1'b0) begin errors++; $display("FAIL midreset k=%0d valids got %b%b exp 00", k, if_valid, d_valid); end
      if (k >= 1 && k <= 6) begin
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL midreset k=%0d stall got %b exp 1", k, stall); end
      end
      if (k >= 2 && k <= 6) begin
        checks++; if (dbg_state !== 1'b0) begin errors++; $display("FAIL midreset k=%0d state got %b exp 0", k, dbg_state); end
      end
      if (k == 7) begin
        checks++; if (dbg_state !== 1'b1) begin errors++; $display("FAIL midreset reload state got %b exp 1", dbg_state); end
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_random();
    ret_t ret_q[$];
    int   starve = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      bit exp_iv, exp_dv, exp_dg, exp_ig, exp_stall, exp_derr, mis, forced;
      logic [31:0] exp_idata, exp_ipc, exp_ddata;
      ret_t e;

      idle_inputs();
      if_req   = ($urandom_range(0, 9) < 7);
      if_addr  = START + 32'(4 * $urandom_range(0, 15));
      d_req    = ($urandom_range(0, 9) < 6);
      d_wr     = ($urandom_range(0, 2) == 0);
      d_addr   = START + 32'(4 * $urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) d_addr = d_addr + 32'($urandom_range(1, 3));
      d_wdata  = $urandom();
      mem_busy = ($urandom_range(0, 9) == 0);
      flush    = ($urandom_range(0, 19) == 0);
      load_req = $urandom_range(0, 1);
      load_addr = $urandom();

      // Flush kills every fetch already in flight, including one due now.
      if (flush) foreach (ret_q[i]) if (ret_q[i].fetch) ret_q[i].live = 0;
      exp_iv = 0; exp_dv = 0; exp_idata = '0; exp_ipc = '0; exp_ddata = '0;
      if (ret_q.size() > 0 && ret_q[0].due == cyc) begin
        e = ret_q.pop_front();
        exp_iv = e.fetch && e.live;
        exp_dv = !e.fetch;
        exp_idata = e.data; exp_ipc = e.pc; exp_ddata = e.data;
      end

      mis       = (d_addr[1:0] != 2'b00);
      exp_derr  = d_req && mis;
      forced    = if_req && (starve >= STARVE_MAX);
      exp_dg    = !mem_busy && d_req && !mis && !forced;
      exp_ig    = !mem_busy && if_req && !exp_dg;
      exp_stall = if_req && !exp_ig;

      @(negedge clock);
      checks++; if (d_gnt !== exp_dg || if_gnt !== exp_ig) begin errors++; $display("FAIL rand c=%0d d_gnt/if_gnt got %b%b exp %b%b", cyc, d_gnt, if_gnt, exp_dg, exp_ig); end
      checks++; if (stall !== exp_stall) begin errors++; $display("FAIL rand c=%0d stall got %b exp %b", cyc, stall, exp_stall); end
      checks++; if (d_err !== exp_derr) begin errors++; $display("FAIL rand c=%0d d_err got %b exp %b", cyc, d_err, exp_derr); end
      checks++; if (load_gnt !== 1'b0) begin errors++; $display("FAIL rand c=%0d load_gnt got %b exp 0", cyc, load_gnt); end
      checks++; if (mem_enable !== (exp_dg || exp_ig)) begin errors++; $display("FAIL rand c=%0d mem_enable got %b exp %b", cyc, mem_enable, exp_dg || exp_ig); end
      if (exp_dg) begin
        checks++; if (mem_addr !== d_addr || mem_wren !== d_wr) begin errors++; $display("FAIL rand c=%0d data port addr/wren got %h %b exp %h %b", cyc, mem_addr, mem_wren, d_addr, d_wr); end
        if (d_wr) begin
          checks++; if (mem_data_in !== d_wdata) begin errors++; $display("FAIL rand c=%0d mem_data_in got %h exp %h", cyc, mem_data_in, d_wdata); end
        end
      end
      if (exp_ig) begin
        checks++; if (mem_addr !== if_addr || mem_wren !== 1'b0) begin errors++; $display("FAIL rand c=%0d fetch port addr/wren got %h %b exp %h 0", cyc, mem_addr, mem_wren, if_addr); end
      end
      checks++; if (if_valid !== exp_iv || d_valid !== exp_dv) begin errors++; $display("FAIL rand c=%0d if_valid/d_valid got %b%b exp %b%b", cyc, if_valid, d_valid, exp_iv, exp_dv); end
      if (exp_iv) begin
        checks++; if (if_data !== exp_idata || if_pc !== exp_ipc) begin errors++; $display("FAIL rand c=%0d if_data/pc got %h %h exp %h %h", cyc, if_data, if_pc, exp_idata, exp_ipc); end
      end
      if (exp_dv) begin
        checks++; if (d_rdata !== exp_ddata) begin errors++; $display("FAIL rand c=%0d d_rdata got %h exp %h", cyc, d_rdata, exp_ddata); end
      end

      if (exp_dg && !d_wr) ret_q.push_back('{due: cyc + RD_LAT, fetch: 1'b0, pc: '0, data: ref_read(d_addr), live: 1'b1});
      if (exp_dg && d_wr) ref_mem[d_addr] = d_wdata;
      if (exp_ig) ret_q.push_back('{due: cyc + RD_LAT, fetch: 1'b1, pc: if_addr, data: ref_read(if_addr), live: 1'b1});
      if (!if_req || exp_ig) starve = 0;
      else if (exp_dg) starve++;
      next_cycle();
    end
    idle_inputs();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks = 0;
    errors = 0;
    words[0] = 32'h1111_0001;
    words[1] = 32'h2222_0002;
    words[2] = 32'h3333_0003;
    idle_inputs();
    reset_n = 0;
    test_reset();
    test_load();
    idle(3);
    test_fetch_b2b();
    idle(3);
    test_data_priority();
    idle(3);
    test_starvation();
    idle(RD_LAT + 3);
    test_misaligned();
    idle(3);
    test_flush();
    idle(3);
    test_busy();
    idle(3);
    test_reset_midflight();
    idle(RD_LAT + 3);
    test_random();
    idle(RD_LAT + 2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Owns the single mainMem port and shares it among three requesters: the program loader (preload writes), instruction fetch, and the data (load/store) stage. After reset it grants the loader exclusively, then runs a pipelined read/write scheduler. Read data returns tagged to its owner, and the fetch stage sees a `stall` whenever it loses arbitration. It sits between fetch/decode/memory stages and mainMem.

Parameters:
START_ADDRESS, 32'h80020000, value driven on if_pc_start; the first fetch address after load completes
RD_LAT, 1, cycles from read issue (mem_enable=1, mem_wren=0) to mem_data_out valid; 1..4
STARVE_MAX, 4, max consecutive data grants while if_req is pending before fetch is forced a grant

Ports:
clock  in  1  rising-edge clock
reset_n  in  1  synchronous, active-low reset
load_req  in  1  loader write request (valid in LOAD state only)
load_addr  in  [0:31]  loader write address
load_data  in  [0:31]  loader write data
load_done  in  1  one-cycle pulse; loader finished
load_gnt  out  1  loader write issued this cycle
if_req  in  1  fetch read request
if_addr  in  [0:31]  fetch PC
if_gnt  out  1  fetch read issued this cycle
if_valid  out  1  instruction returned
if_data  out  [0:31]  instruction word
if_pc  out  [0:31]  PC of returned instruction
if_pc_start  out  [0:31]  equals START_ADDRESS
stall  out  1  fetch must hold PC this cycle
flush  in  1  squash all outstanding fetch returns
d_req  in  1  data request
d_wr  in  1  1 = store, 0 = load
d_addr  in  [0:31]  data address
d_wdata  in  [0:31]  store data
d_gnt  out  1  data access issued this cycle
d_valid  out  1  load data returned
d_rdata  out  [0:31]  load data
d_err  out  1  one-cycle pulse; misaligned request rejected
mem_addr  out  [0:31]  to mainMem addr
mem_data_in  out  [0:31]  to mainMem data_in
mem_data_out  in  [0:31]  from mainMem data_out
mem_acc_size  out  [0:1]  always 2'b00 (single word)
mem_wren  out  1  to mainMem wren
mem_enable  out  1  to mainMem enable
mem_busy  in  1  mainMem busy

Behaviour:
- Reset (reset_n=0 at a clock edge): state LOAD. All grants, valids, d_err, mem_wren, and mem_enable are 0. stall=1. The tag pipe is cleared. The starvation counter is 0. if_data, d_rdata, and mem_addr are 0. Reset asserted mid-operation discards in-flight reads; no valid fires afterward.
- State LOAD:
  - load_req=1 and mem_busy=0 → combinational issue that cycle: mem_enable=1, mem_wren=1, mem_addr=load_addr, mem_data_in=load_data, load_gnt=1.
  - if_req and d_req are ignored; stall=1.
  - load_done → state RUN on the next cycle. A load_req in the same cycle as load_done is still issued.
- State RUN:
  - load_req is ignored; load_gnt=0.
  - At most one issue per cycle, and none while mem_busy=1. While mem_busy=1, all outputs except returns hold.
  - Priority: d_req over if_req. Exception: when the starvation counter reaches STARVE_MAX and if_req=1, fetch wins.
  - Starvation counter: increments on each data grant made while if_req=1; clears on any fetch grant or when if_req=0.
  - stall = if_req & ~if_gnt.
- Misaligned data request (d_addr[30:31]≠0): no issue, no d_gnt, d_err=1 that cycle. Fetch may take the port that cycle.
- Store: completes on issue. No return.
- Read issue pushes tag {owner I/D, pc} into an RD_LAT-deep shift pipe. After exactly RD_LAT cycles, the matching valid is 1 with data = mem_data_out. Fetch returns also drive if_pc from the tag. Back-to-back reads return back-to-back, in order.
- flush=1: every in-flight fetch tag is marked dead, so the corresponding if_valid never fires. A fetch issued in the flush cycle itself is not squashed. Data tags are unaffected.
- Address wrap: no address arithmetic is performed; addresses pass through unchanged.
- Simultaneous d_req and if_req with mem_busy=1: nothing is granted. Requesters hold their requests; priority is re-evaluated when busy drops.

Test Plan:
- Reset, then load 3 words at 0x80020000/04/08, then load_done → 3 load_gnt pulses with mem_wren=1; state RUN on the next cycle; stall=1 throughout LOAD.
- RUN, if_req with if_addr 0x80020000,04,08 back-to-back, RD_LAT=1 → if_valid on cycles 2,3,4 with the preloaded words and if_pc matching; stall=0.
- d_req load 0x80020004 concurrent with if_req → d_gnt first, stall=1 for 1 cycle, d_valid after RD_LAT with the correct word; fetch is granted the next cycle.
- d_req held continuously with if_req, STARVE_MAX=4 → 4 data grants then 1 fetch grant, repeating.
- d_addr 0x80020002 → d_err=1, no mem_enable, no d_gnt. Separately, flush one cycle after 2 fetch issues (RD_LAT=2) → no if_valid for either fetch.
- mem_busy=1 for 3 cycles with both requests pending → no grants, stall=1; grants resume the cycle busy drops.
